// File: rtl/sobel_edge_stream.sv
// Streaming 3x3 Sobel edge detector with frame tracking.
// Two line buffers, 3x3 window, then gradient and magnitude stages.
module sobel_edge_stream #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  input  logic               s_sof,
  input  logic [PIX_W-1:0]   s_pixel,
  input  logic               cfg_mode,
  input  logic [PIX_W+2:0]   cfg_threshold,
  output logic               m_valid,
  output logic               m_sol,
  output logic               m_eol,
  output logic [PIX_W-1:0]   m_pixel,
  output logic               frame_done,
  output logic               err_sticky
);

  localparam int G  = PIX_W + 3;
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] C_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] C_TWO  = CW'(2);
  localparam logic [RW-1:0] R_TWO  = RW'(2);

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic            r_mode;
  logic [G-1:0]    r_thr;

  logic            w_acc;
  logic [CW-1:0]   w_col;
  logic [RW-1:0]   w_row;
  logic            w_qual;
  logic            w_clast;
  logic            w_rlast;

  // A s_sof pixel is always position (0,0), also as a restart.
  assign w_acc   = s_valid && (s_sof || (r_state == S_ACTIVE));
  assign w_col   = s_sof ? '0 : r_col;
  assign w_row   = s_sof ? '0 : r_row;
  assign w_clast = (w_col == C_LAST);
  assign w_rlast = (w_row == R_LAST);
  assign w_qual  = w_acc && (w_row >= R_TWO) && (w_col >= C_TWO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_col      <= '0;
      r_row      <= '0;
      r_mode     <= 1'b0;
      r_thr      <= '0;
      err_sticky <= 1'b0;
    end else if (s_valid) begin
      if (w_acc) begin
        if (s_sof) begin
          r_mode <= cfg_mode;
          r_thr  <= cfg_threshold;
        end
        if (w_clast) begin
          r_col <= '0;
          if (w_rlast) begin
            r_row   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_row   <= w_row + RW'(1);
            r_state <= S_ACTIVE;
          end
        end else begin
          r_col   <= w_col + CW'(1);
          r_row   <= w_row;
          r_state <= S_ACTIVE;
        end
      end else begin
        err_sticky <= 1'b1;
      end
    end
  end

  logic [PIX_W-1:0] r_lb1 [IMG_WIDTH];
  logic [PIX_W-1:0] r_lb2 [IMG_WIDTH];
  logic [PIX_W-1:0] w_up1;
  logic [PIX_W-1:0] w_up2;

  assign w_up1 = r_lb1[w_col];
  assign w_up2 = r_lb2[w_col];

  // r_lb1 holds row r-1, r_lb2 holds row r-2 at the current column.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb1[w_col] <= s_pixel;
      r_lb2[w_col] <= w_up1;
    end
  end

  logic [PIX_W-1:0] r_w [3][3];

  always_ff @(posedge clk) begin
    if (w_acc) begin
      for (int y = 0; y < 3; y++) begin
        r_w[y][0] <= r_w[y][1];
        r_w[y][1] <= r_w[y][2];
      end
      r_w[0][2] <= w_up2;
      r_w[1][2] <= w_up1;
      r_w[2][2] <= s_pixel;
    end
  end

  logic r_v1;
  logic r_sol1;
  logic r_eol1;
  logic r_fd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_sol1 <= 1'b0;
      r_eol1 <= 1'b0;
      r_fd1  <= 1'b0;
    end else begin
      r_v1   <= w_qual;
      r_sol1 <= w_qual && (w_col == C_TWO);
      r_eol1 <= w_qual && w_clast;
      r_fd1  <= w_qual && w_clast && w_rlast;
    end
  end

  logic         r_mode1;
  logic [G-1:0] r_thr1;

  always_ff @(posedge clk) begin
    if (w_qual) begin
      r_mode1 <= r_mode;
      r_thr1  <= r_thr;
    end
  end

  function automatic logic [G-1:0] ext(input logic [PIX_W-1:0] p);
    return G'(p);
  endfunction

  logic [G-1:0] w_gx;
  logic [G-1:0] w_gy;

  // Two's-complement wrap in G bits is exact: |g| <= 4*(2^PIX_W-1).
  assign w_gx = (ext(r_w[0][2]) + (ext(r_w[1][2]) << 1) + ext(r_w[2][2]))
              - (ext(r_w[0][0]) + (ext(r_w[1][0]) << 1) + ext(r_w[2][0]));
  assign w_gy = (ext(r_w[0][0]) + (ext(r_w[0][1]) << 1) + ext(r_w[0][2]))
              - (ext(r_w[2][0]) + (ext(r_w[2][1]) << 1) + ext(r_w[2][2]));

  logic         r_v2;
  logic         r_sol2;
  logic         r_eol2;
  logic         r_fd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_sol2 <= 1'b0;
      r_eol2 <= 1'b0;
      r_fd2  <= 1'b0;
    end else begin
      r_v2   <= r_v1;
      r_sol2 <= r_sol1;
      r_eol2 <= r_eol1;
      r_fd2  <= r_fd1;
    end
  end

  logic [G-1:0] r_gx;
  logic [G-1:0] r_gy;
  logic         r_mode2;
  logic [G-1:0] r_thr2;

  always_ff @(posedge clk) begin
    r_gx    <= w_gx;
    r_gy    <= w_gy;
    r_mode2 <= r_mode1;
    r_thr2  <= r_thr1;
  end

  logic [G-1:0]     w_ax;
  logic [G-1:0]     w_ay;
  logic [G-1:0]     w_mag;
  logic             w_sat;
  logic [PIX_W-1:0] w_res;

  assign w_ax  = r_gx[G-1] ? (G'(0) - r_gx) : r_gx;
  assign w_ay  = r_gy[G-1] ? (G'(0) - r_gy) : r_gy;
  assign w_mag = w_ax + w_ay;
  assign w_sat = |w_mag[G-1:PIX_W];

  always_comb begin
    w_res = '0;
    unique case (1'b1)
      r_mode2:  w_res = w_sat ? '1 : w_mag[PIX_W-1:0];
      !r_mode2: w_res = (w_mag > r_thr2) ? '1 : '0;
      default:  w_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      m_sol      <= 1'b0;
      m_eol      <= 1'b0;
      m_pixel    <= '0;
      frame_done <= 1'b0;
    end else begin
      m_valid    <= r_v2;
      m_sol      <= r_sol2;
      m_eol      <= r_eol2;
      m_pixel    <= r_v2 ? w_res : '0;
      frame_done <= r_fd2;
    end
  end

endmodule
